// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer.
//   - ALU control codes {A_invert, B_invert, op[1:0]}
//   - sequencer state encoding
//   - ctrl_legal(): true for the six supported control codes
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic ctrl_legal(input logic [3:0] ctrl);
        return ctrl inside {CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR};
    endfunction

endpackage

// File: rtl/serial_alu_seq_bit_cell.sv
// serial_bit_cell: combinational 1-bit ALU slice.
//   a, b         operand bits (before inversion)
//   a_invert     invert a
//   b_invert     invert b
//   op           00 AND, 01 OR, 10 sum, 11 SLT (result bit forced 0)
//   cin          carry into this bit
//   res          selected result bit
//   sum          full-adder sum (used for the SLT decision at the MSB)
//   cout         full-adder carry out
module serial_bit_cell (
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic [1:0] op,
    input  logic       cin,
    output logic       res,
    output logic       sum,
    output logic       cout
);

    logic a_eff, b_eff;

    assign a_eff = a ^ a_invert;
    assign b_eff = b ^ b_invert;
    assign sum   = a_eff ^ b_eff ^ cin;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

    always_comb begin
        res = 1'b0;
        unique case (op)
            2'b00:   res = a_eff & b_eff;
            2'b01:   res = a_eff | b_eff;
            2'b10:   res = sum;
            default: res = 1'b0;  // SLT: low bits are zero, bit 0 fixed at the MSB
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU sequencer.
// Latches an operand pair and control code on start, then walks one
// serial_bit_cell across the operands LSB first, one bit per cycle, keeping
// the ripple carry in a flop. Result and flags are published on the final bit.
//   clk_i       clock, rising edge
//   rst_n       asynchronous active-low reset
//   start_i     request, sampled in IDLE or DONE
//   ctrl_i      {A_invert, B_invert, op[1:0]}
//   src1_i      operand A
//   src2_i      operand B
//   busy_o      high while calculating
//   done_o      one-cycle pulse, result valid
//   result_o    result, held until the next operation completes
//   zero_o      result_o == 0
//   cout_o      carry out of MSB (ADD/SUB/SLT)
//   overflow_o  signed overflow (ADD/SUB)
module serial_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q, b_q, work_q;
    logic [3:0]       ctrl_q;

    logic             accept, last_bit;
    logic             cell_res, cell_sum, cell_cout, ov_int;
    logic [WIDTH-1:0] merged, fin_res;
    logic             fin_zero, fin_cout, fin_ov;

    assign accept   = start_i && (state_q == IDLE || state_q == DONE);
    assign last_bit = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH-1));
    assign busy_o   = (state_q == CALC);
    assign done_o   = (state_q == DONE);

    serial_bit_cell u_cell (
        .a        (a_q[cnt_q]),
        .b        (b_q[cnt_q]),
        .a_invert (ctrl_q[3]),
        .b_invert (ctrl_q[2]),
        .op       (ctrl_q[1:0]),
        .cin      (carry_q),
        .res      (cell_res),
        .sum      (cell_sum),
        .cout     (cell_cout)
    );

    // Working result with the current bit dropped in; at the last bit this
    // is the complete plain result.
    always_comb begin
        merged        = work_q;
        merged[cnt_q] = cell_res;
    end

    // Final result/flags, only consumed on the last bit. carry_q is then the
    // carry into the MSB, so overflow is carry-in ^ carry-out of the MSB.
    always_comb begin
        fin_res  = '0;
        fin_zero = 1'b0;
        fin_cout = 1'b0;
        fin_ov   = 1'b0;
        ov_int   = carry_q ^ cell_cout;
        if (ctrl_legal(ctrl_q)) begin
            unique case (ctrl_q[1:0])
                2'b11: begin
                    fin_res  = {{(WIDTH-1){1'b0}}, cell_sum ^ ov_int};
                    fin_cout = cell_cout;
                end
                2'b10: begin
                    fin_res  = merged;
                    fin_cout = cell_cout;
                    fin_ov   = ov_int;
                end
                default: fin_res = merged;
            endcase
            fin_zero = (fin_res == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = CALC;
            CALC:    if (last_bit) state_d = DONE;
            DONE:    state_d = start_i ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ctrl_q     <= '0;
            work_q     <= '0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else if (accept) begin
            a_q     <= src1_i;
            b_q     <= src2_i;
            ctrl_q  <= ctrl_i;
            carry_q <= ctrl_i[2];  // +1 of the two's-complement negate
            cnt_q   <= '0;
            work_q  <= '0;
        end else if (state_q == CALC) begin
            work_q  <= merged;
            carry_q <= cell_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                result_o   <= fin_res;
                zero_o     <= fin_zero;
                cout_o     <= fin_cout;
                overflow_o <= fin_ov;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_seq.sv
module tb_serial_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
        int           cyc;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [3:0]   ctrl_i;
    logic [W-1:0] src1_i, src2_i;
    logic         busy_o, done_o, zero_o, cout_o, overflow_o;
    logic [W-1:0] result_o;

    int           cyc = 0;
    int           checks = 0;
    int           passes = 0;
    exp_t         sb[$];
    int           done_hist[$];
    logic [W-1:0] last_res = '0;
    exp_t         mon_e;

    serial_alu_seq #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .ctrl_i     (ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish by 2000000 want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Reference: whole-word arithmetic straight from the op definitions.
    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W:0] s;
        e.res = '0; e.z = 1'b0; e.c = 1'b0; e.v = 1'b0; e.cyc = 0;
        s = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        case (c)
            CTRL_AND: e.res = a & b;
            CTRL_OR:  e.res = a | b;
            CTRL_NOR: e.res = ~(a | b);
            CTRL_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            CTRL_SUB: begin
                e.res = s[W-1:0];
                e.c = s[W];
                e.v = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
            end
            CTRL_SLT: begin
                e.res = ($signed(a) < $signed(b)) ? W'(1) : '0;
                e.c = s[W];
            end
            default: return e;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Monitor: every done_o pulse consumes one expectation.
    always @(negedge clk_i) begin
        if (rst_n === 1'b1 && done_o === 1'b1) begin
            done_hist.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d want 0", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", W'(cyc), W'(mon_e.cyc));
                chk("result", result_o, mon_e.res);
                chk("zero", W'(zero_o), W'(mon_e.z));
                chk("cout", W'(cout_o), W'(mon_e.c));
                chk("overflow", W'(overflow_o), W'(mon_e.v));
                last_res = mon_e.res;
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, input bit track);
        exp_t e;
        int n;
        ctrl_i = c; src1_i = a; src2_i = b; start_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (busy_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL accept_timeout: got busy_o=1 for %0d cycles want idle", n);
            start_i = 1'b0;
            step(1);
            return;
        end
        @(posedge clk_i);
        #1;
        if (track) begin
            e = model(c, a, b);
            e.cyc = cyc + W;
            sb.push_back(e);
        end
        chk("busy_after_accept", W'(busy_o), W'(1));
        if (!hold) begin
            start_i = 1'b0;
            src1_i = $urandom;  // operands must already be latched
            src2_i = $urandom;
            ctrl_i = 4'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        step(1);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] pick_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] codes [6] = '{CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_SLT, CTRL_NOR};

    initial begin
        logic [3:0] c;
        rst_n = 1'b0; start_i = 1'b0; ctrl_i = '0; src1_i = '0; src2_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_busy", W'(busy_o), '0);
        chk("reset_done", W'(done_o), '0);
        chk("reset_result", result_o, '0);
        chk("reset_flags", W'({zero_o, cout_o, overflow_o}), '0);
        @(negedge clk_i);
        rst_n = 1'b1;
        step(1);

        issue(CTRL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1);
        drain();
        issue(CTRL_SUB, 32'd5, 32'd5, 0, 1);
        issue(CTRL_SLT, 32'hFFFF_FFFD, 32'd2, 0, 1);
        issue(CTRL_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1);
        issue(CTRL_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1);
        issue(CTRL_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1);
        issue(CTRL_NOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 1);
        drain();
        step(3);
        chk("result_held", result_o, last_res);

        // Back-to-back: start held high through CALC and DONE.
        done_hist.delete();
        issue(CTRL_ADD, 32'h1234_5678, 32'h0FED_CBA9, 1, 1);
        issue(CTRL_SUB, 32'h0000_0003, 32'h0000_0009, 0, 1);
        drain();
        if (done_hist.size() == 2) chk("b2b_period", W'(done_hist[1] - done_hist[0]), W'(W + 1));
        else begin
            checks++;
            $display("FAIL b2b_pulses: got %0d done pulses want 2", done_hist.size());
        end

        // Reset in the middle of an ADD: no done, outputs cleared at once.
        issue(CTRL_ADD, 32'h0000_0100, 32'h0000_0200, 0, 0);
        step(10);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", W'(busy_o), '0);
        chk("abort_done", W'(done_o), '0);
        chk("abort_result", result_o, '0);
        chk("abort_flags", W'({zero_o, cout_o, overflow_o}), '0);
        step(2);
        @(negedge clk_i);
        rst_n = 1'b1;
        step(W + 5);
        issue(CTRL_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1);
        issue(4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1);
        drain();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) c = 4'($urandom_range(0, 15));
            else c = codes[$urandom_range(0, 5)];
            issue(c, pick_op(), pick_op(), (i != 39) && ($urandom_range(0, 2) == 0), 1);
        end
        drain();
        step(W + 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
